// File: rtl/mem_seq.sv
// Two-word fetch/execute sequencer driving an external synchronous RAM.
// Optional single-instruction stepping: define STEP_EN to add the `step` input.
module mem_seq #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
`ifdef STEP_EN
  input  logic              step,
`endif
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic              waits,
  output logic              fetcha,
  output logic              fetchb,
  output logic              execa,
  output logic              execb,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ira,
  output logic [DATA_W-1:0] irb,
  output logic [DATA_W-1:0] acc
);

  typedef enum logic [2:0] {
    S_WAIT, S_FETCHA, S_FETCHB, S_EXECA, S_EXECB, S_HALTED
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_JMP   = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_ira;
  logic [DATA_W-1:0]   r_irb;
  logic [DATA_W-1:0]   r_acc;
  logic                r_load_pend;

  logic [1:0]          w_op;
  logic [ADDR_W-1:0]   w_opnd;
  logic                w_start;

  assign w_op   = r_ira[DATA_W-1:DATA_W-2];
  assign w_opnd = r_irb[ADDR_W-1:0];

`ifdef STEP_EN
  assign w_start = run | step;
`else
  assign w_start = run;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_WAIT;
      r_pc        <= ADDR_W'(START_ADDR);
      r_ira       <= '0;
      r_irb       <= '0;
      r_acc       <= '0;
      r_load_pend <= 1'b0;
    end else begin
      // LOAD data returns one cycle after EXECB, whatever state follows it.
      if (r_load_pend) begin
        r_acc       <= mem_rdata;
        r_load_pend <= 1'b0;
      end
      case (r_state)
        S_WAIT: begin
          if (w_start) r_state <= S_FETCHA;
        end
        S_FETCHA: begin
          r_pc    <= r_pc + ADDR_W'(1);
          r_state <= S_FETCHB;
        end
        S_FETCHB: begin
          r_pc    <= r_pc + ADDR_W'(1);
          r_ira   <= mem_rdata;
          r_state <= S_EXECA;
        end
        S_EXECA: begin
          r_irb   <= mem_rdata;
          r_state <= S_EXECB;
        end
        S_EXECB: begin
          case (w_op)
            OP_LOAD: r_load_pend <= 1'b1;
            OP_JMP:  r_pc        <= w_opnd;
            default: ;
          endcase
          if (w_op == OP_HALT) r_state <= S_HALTED;
          else                 r_state <= run ? S_FETCHA : S_WAIT;
        end
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_WAIT;
      endcase
    end
  end

  // Bus is a pure decode of the registered state, so it is idle right after reset.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rden  = 1'b0;
    mem_wren  = 1'b0;
    case (r_state)
      S_FETCHA, S_FETCHB: begin
        mem_addr = r_pc;
        mem_rden = 1'b1;
      end
      S_EXECB: begin
        mem_addr = w_opnd;
        if (w_op == OP_LOAD) mem_rden = 1'b1;
        if (w_op == OP_STORE) begin
          mem_wren  = 1'b1;
          mem_wdata = r_acc;
        end
      end
      default: ;
    endcase
  end

  assign waits  = (r_state == S_WAIT);
  assign fetcha = (r_state == S_FETCHA);
  assign fetchb = (r_state == S_FETCHB);
  assign execa  = (r_state == S_EXECA);
  assign execb  = (r_state == S_EXECB);
  assign halted = (r_state == S_HALTED);

  assign pc  = r_pc;
  assign ira = r_ira;
  assign irb = r_irb;
  assign acc = r_acc;

endmodule

// File: tb/tb_mem_seq.sv
// Bench for mem_seq: directed cycle checks plus random programs scored against an
// instruction-level reference model. Observed events are RAM writes and halt entry.
module tb_mem_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
`ifdef STEP_EN
  logic       step = 1'b0;
`endif
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem_addr, mem_wdata, pc, ira, irb, acc;
  logic       mem_rden, mem_wren;
  logic       waits, fetcha, fetchb, execa, execb, halted;

  logic [7:0] ram [256];

  int checks   = 0;
  int failures = 0;

  // Expected event: {kind(0=write,1=halt), addr_or_pc, data_or_acc}
  logic [16:0] exp_q[$];
  logic [16:0] ref_q[$];

  bit mon_en      = 1'b0;
  bit prev_halted = 1'b0;

  always #5 clk = ~clk;

  mem_seq #(.DATA_W(8), .ADDR_W(8), .START_ADDR(0)) dut (
    .clk(clk), .rst(rst), .run(run),
`ifdef STEP_EN
    .step(step),
`endif
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rden(mem_rden), .mem_wren(mem_wren),
    .waits(waits), .fetcha(fetcha), .fetchb(fetchb), .execa(execa),
    .execb(execb), .halted(halted),
    .pc(pc), .ira(ira), .irb(irb), .acc(acc)
  );

  // Synchronous RAM model: q valid the cycle after the read address.
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    if (mem_rden) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected queue whenever the DUT writes RAM or enters HALTED.
  always @(negedge clk) begin
    if (mon_en) begin
      check("one_hot_state", 32'($countones({waits, fetcha, fetchb, execa, execb, halted})), 1);
      if (waits || execa || halted)
        check("idle_bus", {14'd0, mem_addr, mem_wdata, mem_rden, mem_wren}, 0);
      if (mem_wren) begin
        check("rden_wren_excl", 32'(mem_rden), 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: addr %0h data %0h at %0t", mem_addr, mem_wdata, $time);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check("write_kind", 32'(e[16]), 0);
          check("write_addr", 32'(mem_addr), 32'(e[15:8]));
          check("write_data", 32'(mem_wdata), 32'(e[7:0]));
        end
      end
      if (halted && !prev_halted) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_halt: pc %0h acc %0h at %0t", pc, acc, $time);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check("halt_kind", 32'(e[16]), 1);
          check("halt_pc", 32'(pc), 32'(e[15:8]));
          check("halt_acc", 32'(acc), 32'(e[7:0]));
        end
      end
      prev_halted = halted;
    end
  end

  // Instruction-level model: runs the program in ram from address 0 with acc=0.
  task automatic ref_run(output bit ok);
    logic [7:0] m [256];
    logic [7:0] p, a, ia, ib;
    ref_q.delete();
    for (int i = 0; i < 256; i++) m[i] = ram[i];
    p  = 8'h00;
    a  = 8'h00;
    ok = 1'b0;
    for (int n = 0; n < 64 && !ok; n++) begin
      ia = m[p]; p = p + 8'd1;
      ib = m[p]; p = p + 8'd1;
      case (ia[7:6])
        2'd0: a = m[ib];
        2'd1: begin m[ib] = a; ref_q.push_back({1'b0, ib, a}); end
        2'd2: p = ib;
        default: begin ref_q.push_back({1'b1, p, a}); ok = 1'b1; end
      endcase
    end
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
  endtask

  // Reset edge is E0; returns at the negedge of cycle 0.
  task automatic do_reset(input logic run_val);
    rst = 1'b1;
    run = run_val;
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic wait_halt(input int budget, input bit rand_run);
    for (int i = 0; i < budget && !halted; i++) begin
      @(negedge clk);
      if (rand_run) run = ($urandom_range(0, 3) != 0);
    end
    check("halt_reached", 32'(halted), 1);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;

    // 1. Reset with run held high.
    clear_ram();
    do_reset(1'b1);
    check("rst_waits", 32'(waits), 1);
    check("rst_pc", 32'(pc), 0);
    check("rst_ira", 32'(ira), 0);
    check("rst_irb", 32'(irb), 0);
    check("rst_acc", 32'(acc), 0);
    check("rst_enables", {30'd0, mem_rden, mem_wren}, 0);

    // 2. LOAD 10, STORE 20, HALT.
    rst = 1'b1;
    clear_ram();
    ram[0] = 8'h00; ram[1] = 8'h10; ram[2] = 8'h40; ram[3] = 8'h20;
    ram[4] = 8'hC0; ram[5] = 8'h00; ram[8'h10] = 8'hA5;
    exp_q.push_back({1'b0, 8'h20, 8'hA5});
    exp_q.push_back({1'b1, 8'h06, 8'hA5});
    do_reset(1'b1);
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check("p2_fetcha0", {fetcha, mem_rden, mem_addr}, {1'b1, 1'b1, 8'h00});
      if (cyc == 4) check("p2_load_rd", {execb, mem_rden, mem_addr}, {1'b1, 1'b1, 8'h10});
      if (cyc == 6) check("p2_acc", 32'(acc), 32'hA5);
      if (cyc == 8) check("p2_store", {mem_wren, mem_addr, mem_wdata}, {1'b1, 8'h20, 8'hA5});
      if (cyc == 13) check("p2_halt", {halted, pc}, {1'b1, 8'h06});
    end
    @(negedge clk);
    check("p2_ram20", 32'(ram[8'h20]), 32'hA5);
    check("p2_queue", exp_q.size(), 0);
    exp_q.delete();

    // 3. JMP FE, then a JMP sitting across the pc wrap.
    rst = 1'b1;
    clear_ram();
    ram[0] = 8'h80; ram[1] = 8'hFE; ram[8'hFE] = 8'h80; ram[8'hFF] = 8'h03;
    ram[3] = 8'hC0; ram[4] = 8'h00;
    exp_q.push_back({1'b1, 8'h05, 8'h00});
    do_reset(1'b1);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      if (cyc == 5) check("p3_fetch_fe", {fetcha, mem_addr}, {1'b1, 8'hFE});
      if (cyc == 6) check("p3_pc_ff", 32'(pc), 32'hFF);
      if (cyc == 7) check("p3_pc_wrap", 32'(pc), 32'h00);
      if (cyc == 9) check("p3_jmp_target", {fetcha, pc, mem_addr}, {1'b1, 8'h03, 8'h03});
    end
    wait_halt(20, 1'b0);

    // 4. run dropped during FETCHB of a LOAD.
    rst = 1'b1;
    clear_ram();
    ram[0] = 8'h00; ram[1] = 8'h10; ram[2] = 8'hC0; ram[3] = 8'h00;
    ram[8'h10] = 8'h5A;
    exp_q.push_back({1'b1, 8'h04, 8'h5A});
    do_reset(1'b1);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (cyc == 2) run = 1'b0;
      if (cyc == 3) check("p4_execa", 32'(execa), 1);
      if (cyc == 4) check("p4_execb", 32'(execb), 1);
      if (cyc == 5) check("p4_wait", 32'(waits), 1);
      if (cyc == 6) check("p4_acc_in_wait", {waits, acc, pc}, {1'b1, 8'h5A, 8'h02});
      if (cyc == 8) check("p4_pc_hold", {waits, pc}, {1'b1, 8'h02});
    end
    run = 1'b1;
    wait_halt(20, 1'b0);

    // 5. Reset sampled at the EXECA->EXECB edge of a STORE.
    rst = 1'b1;
    clear_ram();
    ram[0] = 8'h40; ram[1] = 8'h30; ram[8'h30] = 8'h77;
    do_reset(1'b1);
    for (int cyc = 1; cyc <= 3; cyc++) @(negedge clk);
    check("p5_in_execa", 32'(execa), 1);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("p5_waits", 32'(waits), 1);
    for (int cyc = 0; cyc < 4; cyc++) @(negedge clk);
    check("p5_ram_kept", 32'(ram[8'h30]), 32'h77);

`ifdef STEP_EN
    // 6. One step pulse runs exactly one instruction.
    begin
      int busy;
      rst = 1'b1;
      clear_ram();
      ram[0] = 8'h00; ram[1] = 8'h10;
      do_reset(1'b0);
      busy = 0;
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      if (!waits) busy++;
      for (int cyc = 0; cyc < 9; cyc++) begin
        @(negedge clk);
        if (!waits) busy++;
      end
      check("p6_busy_cycles", busy, 4);
      check("p6_pc", {waits, pc}, {1'b1, 8'h02});
    end
`endif

    // Random programs with run toggling, scored against the reference model.
    for (int t = 0; t < 25; t++) begin
      rst = 1'b1;
      ok  = 1'b0;
      for (int tries = 0; tries < 30 && !ok; tries++) begin
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom_range(0, 255));
        ref_run(ok);
      end
      if (!ok) begin
        ram[0] = 8'hC0;
        ram[1] = 8'h00;
        ref_run(ok);
      end
      foreach (ref_q[i]) exp_q.push_back(ref_q[i]);
      do_reset(1'b1);
      wait_halt(3000, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
